// File: rtl/hash160_arbiter_pkg.sv
// Shared constants for the hash160 arbiter slice: core geometry, counter widths
// and the encoded FSM states.
package hash160_pkg;

  localparam int DIGEST_W    = 160;
  localparam int BLOCK_BYTES = 64;
  localparam int ANS_BEATS   = 10;
  localparam int ANS_W       = 16;
  localparam int BYTE_CNT_W  = $clog2(BLOCK_BYTES);
  localparam int BEAT_CNT_W  = $clog2(ANS_BEATS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FEED    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_COLLECT = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

endpackage

// File: rtl/hash160_arbiter_if.sv
// Bundle of requester, core and result signals around the hash160 arbiter.
// master = the arbiter itself, slave = clients, core and result consumer.
interface hash160_arbiter_if
  import hash160_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_text;
  logic [NUM_REQ-1:0]   gnt;
  logic                 core_rst;
  logic                 core_i_valid;
  logic [7:0]           core_i_text;
  logic                 core_o_valid;
  logic [ANS_W-1:0]     core_o_answer;
  logic                 res_valid;
  logic [ID_W-1:0]      res_id;
  logic                 res_err;
  logic [DIGEST_W-1:0]  res_digest;
  logic                 res_ready;

  modport master (
    input  req, req_text, core_o_valid, core_o_answer, res_ready,
    output gnt, core_rst, core_i_valid, core_i_text,
           res_valid, res_id, res_err, res_digest
  );

  modport slave (
    output req, req_text, core_o_valid, core_o_answer, res_ready,
    input  gnt, core_rst, core_i_valid, core_i_text,
           res_valid, res_id, res_err, res_digest
  );

endinterface

// File: rtl/hash160_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around; returns both a one-hot grant and the winning index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_pos;

  // One extra bit on the sum lets the wrap work for non power-of-two counts.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_pos = w_sum[ID_W-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = w_pos;
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/hash160_arbiter.sv
// Time-shares one hash160 core between NUM_REQ clients: grant, stream a block,
// watch the core with a watchdog, gather the digest and hand it back.
module hash160_arbiter
  import hash160_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input logic         clk,
  input logic         rst,
  hash160_arbiter_if.master bus
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]            r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_cur_id;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [WD_W-1:0]       r_wd_cnt;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_core_rst;
  logic                  r_core_i_valid;
  logic [7:0]            r_core_i_text;
  logic                  r_res_valid;
  logic                  r_res_err;
  logic [ID_W-1:0]       r_res_id;
  logic [DIGEST_W-1:0]   r_digest;

  logic [NUM_REQ-1:0]    w_arb_gnt;
  logic [ID_W-1:0]       w_arb_idx;
  logic                  w_arb_any;
  logic [7:0]            w_lane;
  logic [ID_W-1:0]       w_ptr_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_lane     = bus.req_text[{r_cur_id, 3'b000} +: 8];
  assign w_ptr_next = (r_cur_id == ID_W'(NUM_REQ-1)) ? '0 : r_cur_id + ID_W'(1);

  // core_rst and core_i_valid are single-cycle strobes, cleared unless re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_cur_id       <= '0;
      r_byte_cnt     <= '0;
      r_wd_cnt       <= '0;
      r_beat_cnt     <= '0;
      r_gnt          <= '0;
      r_core_rst     <= 1'b0;
      r_core_i_valid <= 1'b0;
      r_core_i_text  <= '0;
      r_res_valid    <= 1'b0;
      r_res_err      <= 1'b0;
      r_res_id       <= '0;
      r_digest       <= '0;
    end else begin
      r_core_rst     <= 1'b0;
      r_core_i_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_cur_id   <= w_arb_idx;
            r_gnt      <= w_arb_gnt;
            r_byte_cnt <= '0;
            r_digest   <= '0;
            r_state    <= ST_FEED;
          end
        end
        ST_FEED: begin
          r_core_i_text  <= w_lane;
          r_core_i_valid <= (r_byte_cnt == '0);
          r_byte_cnt     <= r_byte_cnt + BYTE_CNT_W'(1);
          if (r_byte_cnt == BYTE_CNT_W'(BLOCK_BYTES-1)) begin
            r_gnt    <= '0;
            r_wd_cnt <= '0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.core_o_valid) begin
            r_digest   <= {r_digest[DIGEST_W-ANS_W-1:0], bus.core_o_answer};
            r_beat_cnt <= BEAT_CNT_W'(1);
            r_state    <= ST_COLLECT;
          end else if (r_wd_cnt == WD_W'(TIMEOUT-1)) begin
            r_core_rst  <= 1'b1;
            r_res_err   <= 1'b1;
            r_digest    <= '0;
            r_res_id    <= r_cur_id;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end
        ST_COLLECT: begin
          if (bus.core_o_valid) begin
            r_digest   <= {r_digest[DIGEST_W-ANS_W-1:0], bus.core_o_answer};
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            if (r_beat_cnt == BEAT_CNT_W'(ANS_BEATS-1)) begin
              r_res_err   <= 1'b0;
              r_res_id    <= r_cur_id;
              r_res_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.core_rst     = r_core_rst;
  assign bus.core_i_valid = r_core_i_valid;
  assign bus.core_i_text  = r_core_i_text;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_id       = r_res_id;
  assign bus.res_err      = r_res_err;
  assign bus.res_digest   = r_digest;

endmodule

// File: tb/tb_hash160_arbiter.sv
// Directed bench for hash160_arbiter: lane drivers, a small behavioural core
// and one task per scenario with hand-derived expectations.
module tb_hash160_arbiter;
  import hash160_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   coreSilent = 1'b0;
  bit   coreGaps = 1'b0;

  hash160_arbiter_if #(.NUM_REQ(NREQ), .ID_W(IDW)) bus ();

  hash160_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Lane i carries 0x40*i + k during the k-th cycle of its grant.
  int laneCnt [NREQ];
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.gnt[i] === 1'b1) begin
        bus.req_text[i*8 +: 8] = 8'(i*64 + laneCnt[i]);
        laneCnt[i]++;
      end else begin
        laneCnt[i] = 0;
        bus.req_text[i*8 +: 8] = 8'(i*64);
      end
    end
  end

  // Core model: after 64 bytes and 3 idle cycles answers {byte0, n} for n=1..10.
  int         cState = 0;
  int         cCount = 0;
  int         cBeat = 0;
  bit         gapPhase = 1'b0;
  logic [7:0] firstByte = 8'h00;
  always @(negedge clk) begin
    bus.core_o_valid = 1'b0;
    if (rst === 1'b1 || bus.core_rst === 1'b1) begin
      cState = 0;
    end else begin
      case (cState)
        0: if (bus.core_i_valid === 1'b1) begin
             firstByte = bus.core_i_text;
             cCount = 1;
             cState = 1;
           end
        1: begin
             cCount++;
             if (cCount == BLOCK_BYTES) begin
               cCount = 0;
               cState = coreSilent ? 0 : 2;
             end
           end
        2: begin
             cCount++;
             if (cCount == 3) begin
               cBeat = 0;
               gapPhase = 1'b0;
               cState = 3;
             end
           end
        3: if (coreGaps && gapPhase) begin
             gapPhase = 1'b0;
           end else begin
             bus.core_o_valid  = 1'b1;
             bus.core_o_answer = {firstByte, 8'(cBeat + 1)};
             cBeat++;
             gapPhase = 1'b1;
             if (cBeat == ANS_BEATS) cState = 0;
           end
        default: cState = 0;
      endcase
    end
  end

  function automatic logic [DIGEST_W-1:0] expDigest(input int id);
    logic [DIGEST_W-1:0] d;
    d = '0;
    for (int n = 1; n <= ANS_BEATS; n++) d = {d[DIGEST_W-17:0], 8'(id*64), 8'(n)};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.req = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic waitRes(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (bus.res_valid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_res: res_valid still 0 after %0d cycles, expected 1", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus.gnt, bus.core_rst, bus.core_i_valid, bus.core_i_text} !== 14'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_core_side: gnt=%b core_rst=%b core_i_valid=%b core_i_text=%h, expected all 0",
               bus.gnt, bus.core_rst, bus.core_i_valid, bus.core_i_text);
    end
    vectors++;
    if ({bus.res_valid, bus.res_id, bus.res_err} !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_res_flags: res_valid=%b res_id=%0d res_err=%b, expected 0",
               bus.res_valid, bus.res_id, bus.res_err);
    end
    vectors++;
    if (bus.res_digest !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_digest: got %h, expected 0", bus.res_digest);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int gntCycles;
    int badBytes;
    bit ok;
    doReset();
    coreGaps = 1'b1;
    bus.req = 4'b0001;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL single_gnt_latency: gnt=%b, expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    gntCycles = 0;
    badBytes = 0;
    for (int c = 0; c < 66; c++) begin
      if (bus.gnt === 4'b0001) gntCycles++;
      if (c >= 1 && c <= 64) begin
        if (bus.core_i_text !== 8'(c-1) || bus.core_i_valid !== 1'(c == 1)) badBytes++;
      end
      tick();
    end
    vectors++;
    if (gntCycles != 64) begin
      miscompares++;
      $display("[TB] FAIL single_gnt_len: gnt high %0d cycles, expected 64", gntCycles);
    end
    vectors++;
    if (badBytes != 0) begin
      miscompares++;
      $display("[TB] FAIL single_bytes: %0d bad byte/valid samples, expected 0", badBytes);
    end
    waitRes(200, ok);
    if (ok) begin
      vectors++;
      if (bus.core_o_valid !== 1'b1 || bus.core_o_answer !== 16'h000A) begin
        miscompares++;
        $display("[TB] FAIL single_res_latency: beat seen with res_valid valid=%b answer=%h, expected 1/000a",
                 bus.core_o_valid, bus.core_o_answer);
      end
      vectors++;
      if (bus.res_id !== 2'd0 || bus.res_err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL single_id_err: id=%0d err=%b, expected 0/0", bus.res_id, bus.res_err);
      end
      vectors++;
      if (bus.res_digest !== 160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A) begin
        miscompares++;
        $display("[TB] FAIL single_digest: got %h, expected 00010002000300040005000600070008000900 0a", bus.res_digest);
      end
    end
    handshake();
    vectors++;
    if (bus.res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_res_drop: res_valid=%b, expected 0", bus.res_valid);
    end
    coreGaps = 1'b0;
  endtask

  task automatic test_two_requests();
    bit ok;
    doReset();
    bus.req = 4'b0101;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL two_first_gnt: gnt=%b, expected 0001", bus.gnt);
    end
    bus.req = 4'b0100;
    waitRes(300, ok);
    if (ok) begin
      vectors++;
      if (bus.res_id !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL two_first_id: id=%0d, expected 0", bus.res_id);
      end
    end
    handshake();
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL two_bubble: gnt=%b res_valid=%b, expected 0000/0", bus.gnt, bus.res_valid);
    end
    tick();
    vectors++;
    if (bus.gnt !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL two_second_gnt: gnt=%b, expected 0100", bus.gnt);
    end
    bus.req = 4'b0000;
    waitRes(300, ok);
    if (ok) begin
      vectors++;
      if (bus.res_id !== 2'd2 || bus.res_digest !== expDigest(2)) begin
        miscompares++;
        $display("[TB] FAIL two_second_res: id=%0d digest=%h, expected 2/%h",
                 bus.res_id, bus.res_digest, expDigest(2));
      end
    end
    handshake();
  endtask

  task automatic test_round_robin();
    bit ok;
    int expId;
    doReset();
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      waitRes(300, ok);
      if (!ok) break;
      expId = n % NREQ;
      vectors++;
      if (bus.res_id !== 2'(expId) || bus.res_digest !== expDigest(expId)) begin
        miscompares++;
        $display("[TB] FAIL rr_order[%0d]: id=%0d digest=%h, expected %0d/%h",
                 n, bus.res_id, bus.res_digest, expId, expDigest(expId));
      end
      tick();
    end
    bus.req = 4'b0000;
    bus.res_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int stallBad;
    doReset();
    bus.req = 4'b0010;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL bp_gnt: gnt=%b, expected 0010", bus.gnt);
    end
    bus.req = 4'b0001;
    waitRes(300, ok);
    stallBad = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 ||
          bus.res_digest !== expDigest(1) || bus.gnt !== 4'b0000) stallBad++;
      tick();
    end
    vectors++;
    if (stallBad != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_stable: %0d unstable cycles of 20, expected 0", stallBad);
    end
    handshake();
    vectors++;
    if (bus.gnt !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL bp_bubble: gnt=%b, expected 0000", bus.gnt);
    end
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL bp_next_gnt: gnt=%b, expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    waitRes(300, ok);
    handshake();
  endtask

  task automatic test_timeout();
    int n;
    int extraPulses;
    doReset();
    coreSilent = 1'b1;
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b0000;
    n = 0;
    while (bus.gnt !== 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    n = 1;
    while (bus.core_rst !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 17) begin
      miscompares++;
      $display("[TB] FAIL timeout_when: core_rst on cycle %0d after gnt fell, expected 17", n);
    end
    vectors++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_id !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL timeout_res: valid=%b err=%b id=%0d, expected 1/1/3",
               bus.res_valid, bus.res_err, bus.res_id);
    end
    vectors++;
    if (bus.res_digest !== '0) begin
      miscompares++;
      $display("[TB] FAIL timeout_digest: got %h, expected 0", bus.res_digest);
    end
    extraPulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.core_rst !== 1'b0) extraPulses++;
    end
    vectors++;
    if (extraPulses != 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_pulse: core_rst high %0d extra cycles, expected 0", extraPulses);
    end
    handshake();
    coreSilent = 1'b0;
  endtask

  task automatic test_reset_mid_feed();
    bit ok;
    doReset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    waitRes(300, ok);
    handshake();
    bus.req = 4'b0100;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL midrst_gnt: gnt=%b, expected 0100", bus.gnt);
    end
    bus.req = 4'b0000;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.gnt, bus.core_i_valid, bus.res_valid, bus.core_i_text} !== 14'h0) begin
      miscompares++;
      $display("[TB] FAIL midrst_outputs: gnt=%b core_i_valid=%b res_valid=%b text=%h, expected 0",
               bus.gnt, bus.core_i_valid, bus.res_valid, bus.core_i_text);
    end
    rst = 1'b0;
    bus.req = 4'b0101;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL midrst_ptr: gnt=%b, expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    vectors++;
    if (bus.core_i_valid !== 1'b1 || bus.core_i_text !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_restart: valid=%b text=%h, expected 1/00", bus.core_i_valid, bus.core_i_text);
    end
    waitRes(300, ok);
    if (ok) begin
      vectors++;
      if (bus.res_id !== 2'd0 || bus.res_digest !== expDigest(0)) begin
        miscompares++;
        $display("[TB] FAIL midrst_res: id=%0d digest=%h, expected 0/%h",
                 bus.res_id, bus.res_digest, expDigest(0));
      end
    end
    handshake();
  endtask

  initial begin
    bus.req = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_two_requests();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_feed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] aborted");
  end

endmodule

// File: doc/hash160_arbiter.md
Name: hash160_arbiter

Overview:
Shares one hash160 core (sha256 followed by ripemd160) among NUM_REQ requesters.
- Round-robin grant to one requester.
- Streams that requester's 64-byte block into the core.
- Watches the core with a watchdog timer.
- Collects the 16-bit answer beats into a 160-bit digest and returns it with the requester id.
- Sits between client logic and the hash160 core; it is the only driver of the core's input port.

Parameters:
NUM_REQ, 4, number of requesters
ID_W, 2, width of requester id (clog2 NUM_REQ)
BLOCK_BYTES, 64, bytes per block fed to core
ANS_BEATS, 10, 16-bit answer beats per digest
TIMEOUT, 1024, max cycles in WAIT before abort

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-requester request, held high until grant
req_text  in  NUM_REQ*8  per-requester byte lane; lane i = req_text[8i+7:8i]
gnt  out  NUM_REQ  one-hot, high for the BLOCK_BYTES cycles of FEED
core_rst  out  1  one-cycle core reset pulse on timeout
core_i_valid  out  1  high only on the cycle carrying byte 0
core_i_text  out  8  byte to core, registered
core_o_valid  in  1  answer beat valid
core_o_answer  in  16  answer beat, most significant beat first
res_valid  out  1  digest available
res_id  out  ID_W  requester that owns the digest
res_err  out  1  1 = aborted by timeout, digest is zero
res_digest  out  160  collected digest
res_ready  in  1  consumer accepts result

Behaviour:
- Reset is synchronous and active-high: one clock (clk), one reset (rst).
- Reset values: every output is 0, state is IDLE, RR pointer is 0, all counters are 0.
- States: IDLE, FEED, WAIT, COLLECT, RESP.
- IDLE:
  - If any req is set, pick the first set bit at or after the RR pointer, wrapping; latch it as cur_id.
  - Set gnt[cur_id] next cycle, go to FEED, clear byte_cnt.
  - If no req is set, stay in IDLE.
- FEED:
  - gnt[cur_id] stays high for exactly BLOCK_BYTES cycles.
  - Each cycle, register lane cur_id into core_i_text; byte k reaches core_i_text one cycle after the k-th gnt cycle.
  - core_i_valid=1 only with byte 0.
  - byte_cnt counts 0..63. At 63, drop gnt, go to WAIT, clear wd_cnt.
  - req and lane values of other requesters are ignored.
  - A requester dropping req mid-FEED is ignored; bytes are still sampled.
- WAIT:
  - wd_cnt increments each cycle.
  - If core_o_valid=1, shift in beat 0, go to COLLECT with beat_cnt=1.
  - If wd_cnt reaches TIMEOUT-1 with no beat: pulse core_rst for 1 cycle, set res_err=1, set digest to 0, go to RESP.
- COLLECT:
  - On each core_o_valid, shift left: digest = {digest[143:0], core_o_answer}; beat_cnt++.
  - Gaps with core_o_valid=0 are held without aborting.
  - After beat ANS_BEATS-1 is accepted, go to RESP with res_err=0.
- RESP:
  - res_valid=1; res_id, res_err, res_digest are stable until res_ready=1.
  - On that handshake cycle: res_valid drops next cycle, RR pointer = cur_id+1 (wrapping), go to IDLE.
  - One bubble cycle in IDLE before the next grant is required.
- core_o_valid outside WAIT/COLLECT is ignored.
- Latency, request to first gnt: 1 cycle.
- Latency, last gnt cycle to core's last byte: 1 cycle.
- Latency, last answer beat to res_valid: 1 cycle.
- rst mid-operation: all state is discarded and all outputs return to 0 on the next edge; core_rst is NOT pulsed because the core shares rst.
- Fairness: a requester that is continuously set is granted within NUM_REQ arbitrations.

Decomposition:
- Package hash160_pkg:
  - state enum (IDLE, FEED, WAIT, COLLECT, RESP)
  - DIGEST_W=160, BLOCK_BYTES, ANS_BEATS, ANS_W=16
- Sub-module rr_arbiter(NUM_REQ):
  - Pure combinational: inputs req and pointer; outputs one-hot grant and index.
  - Reused by later multi-core schedulers.
- Counters and FSM live in hash160_arbiter.

Test Plan:
- Single request: req=4'b0001, lane 0 bytes 0x00..0x3F; core model returns beats 0x0001..0x000A.
  -> gnt[0] high for 64 cycles; core_i_text carries 0x00..0x3F with core_i_valid only on 0x00; res_valid with res_id=0, res_err=0, res_digest=0x0001_0002_0003_0004_0005_0006_0007_0008_0009_000A.
- Simultaneous requests after reset: req=4'b0101.
  -> requester 0 served first, then requester 2; the second gnt rises 1 cycle after the first result's handshake plus 1 idle cycle.
- Round robin under saturation: req=4'b1111 held for 8 results.
  -> res_id sequence 0,1,2,3,0,1,2,3.
- Back-pressure: res_ready=0 for 20 cycles.
  -> res_valid, res_id, and res_digest are stable all 20 cycles; no new gnt; after res_ready=1, next gnt 2 cycles later.
- Timeout: core model never raises core_o_valid, TIMEOUT=16.
  -> core_rst pulses exactly once, 16 cycles after FEED ends; res_err=1; res_digest=0.
- Reset mid-FEED: assert rst at byte_cnt=30.
  -> next cycle gnt=0, core_i_valid=0, res_valid=0; a fresh req restarts at byte 0 with the pointer at 0.
